axi_lite_read_sweep: RTL

- Parametrised AXI4-Lite read master.
- Sweeps an address window [ADDR_START, ADDR_END] in steps of STRIDE, issuing one single-beat read per address.
- Each returned data word is published on a local result port.
- Adds start/stop control, single-shot or continuous mode, response-error counting and a response timeout.
- Sits in the SPI/FPGA test fabric as a traffic generator and checker in front of AXI4-Lite slaves.

---
 rtl/axi_lite_read_sweep.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_read_sweep.sv
// AXI4-Lite read master sweeping [ADDR_START, ADDR_END] by STRIDE and publishing every returned beat.
// Optional macro SWEEP_CHECKSUM_EN adds an XOR checksum of all accepted read data.
module axi_lite_read_sweep #(
  parameter int                ADDR_W     = 24,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] ADDR_START = 24'h0AB0B9,
  parameter logic [ADDR_W-1:0] ADDR_END   = 24'h0AB0C0,
  parameter int                STRIDE     = 1,
  parameter int                TIMEOUT    = 255,
  parameter int                ERR_W      = 8
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              start,
  input  logic              continuous,
  input  logic              stop,
  output logic              busy,
  output logic              done,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic              rready,
  input  logic              rvalid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  output logic              res_valid,
  output logic [ADDR_W-1:0] res_addr,
  output logic [DATA_W-1:0] res_data,
  output logic [ERR_W-1:0]  err_count,
  output logic [ERR_W-1:0]  to_count,
`ifdef SWEEP_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic [1:0]        dbg_state
);

  // AXI channels: a transfer happens on the rising edge where valid && ready are both high;
  // once raised, valid stays high with a stable payload until that edge, ready may change freely.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_RESP = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  localparam int                TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0]   STEP    = (ADDR_W + 1)'(STRIDE);
  localparam logic [ADDR_W:0]   LAST    = {1'b0, ADDR_END};

  if (ADDR_START > ADDR_END) begin : g_bad_window
    $error("axi_lite_read_sweep: ADDR_START must not exceed ADDR_END");
  end
  if (STRIDE < 1 || TIMEOUT < 1) begin : g_bad_step
    $error("axi_lite_read_sweep: STRIDE and TIMEOUT must be at least 1");
  end

  state_t              r_state;
  logic                r_cont;
  logic                r_busy;
  logic                r_done;
  logic                r_arvalid;
  logic [ADDR_W-1:0]   r_araddr;
  logic                r_rready;
  logic                r_res_valid;
  logic [ADDR_W-1:0]   r_res_addr;
  logic [DATA_W-1:0]   r_res_data;
  logic [ERR_W-1:0]    r_err;
  logic [ERR_W-1:0]    r_to;
  logic [TO_W-1:0]     r_to_cnt;
`ifdef SWEEP_CHECKSUM_EN
  logic [DATA_W-1:0]   r_cksum;
`endif
  logic [ADDR_W:0]     w_nxt;

  // One extra bit so a step past the top of the address space is still seen as beyond ADDR_END.
  assign w_nxt = {1'b0, r_araddr} + STEP;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state     <= S_IDLE;
      r_cont      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_arvalid   <= 1'b0;
      r_araddr    <= ADDR_START;
      r_rready    <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_addr  <= '0;
      r_res_data  <= '0;
      r_err       <= '0;
      r_to        <= '0;
      r_to_cnt    <= '0;
`ifdef SWEEP_CHECKSUM_EN
      r_cksum     <= '0;
`endif
    end else begin
      r_done      <= 1'b0;
      r_res_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cont    <= continuous;
            r_araddr  <= ADDR_START;
            r_busy    <= 1'b1;
            r_arvalid <= 1'b1;
            r_state   <= S_ADDR;
`ifdef SWEEP_CHECKSUM_EN
            r_cksum   <= '0;
`endif
          end
        end
        S_ADDR: begin
          if (r_arvalid && arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_to_cnt  <= '0;
            r_state   <= S_RESP;
          end
        end
        S_RESP: begin
          if (r_rready && rvalid) begin
            r_rready    <= 1'b0;
            r_res_valid <= 1'b1;
            r_res_addr  <= r_araddr;
            r_res_data  <= rdata;
            if (rresp != 2'b00 && !(&r_err)) r_err <= r_err + 1'b1;
`ifdef SWEEP_CHECKSUM_EN
            r_cksum     <= r_cksum ^ rdata;
`endif
            if (stop) begin
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else if (w_nxt > LAST) begin
              if (r_cont) begin
                r_araddr  <= ADDR_START;
                r_arvalid <= 1'b1;
                r_state   <= S_ADDR;
              end else begin
                r_done  <= 1'b1;
                r_state <= S_FIN;
              end
            end else begin
              r_araddr  <= w_nxt[ADDR_W-1:0];
              r_arvalid <= 1'b1;
              r_state   <= S_ADDR;
            end
          end else if (r_to_cnt == TO_LAST) begin
            r_rready <= 1'b0;
            if (!(&r_to)) r_to <= r_to + 1'b1;
            r_done   <= 1'b1;
            r_state  <= S_FIN;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_FIN: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign arvalid   = r_arvalid;
  assign araddr    = r_araddr;
  assign rready    = r_rready;
  assign res_valid = r_res_valid;
  assign res_addr  = r_res_addr;
  assign res_data  = r_res_data;
  assign err_count = r_err;
  assign to_count  = r_to;
  assign dbg_state = r_state;
`ifdef SWEEP_CHECKSUM_EN
  assign checksum  = r_cksum;
`endif

endmodule
